// File: rtl/mdu_scheduler_pkg.sv
// Shared MDU op codes, FSM state type and op-class decode helpers.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_scheduler_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8,
      MD_MADD  = 4'd9,
      MD_MADDU = 4'd10,
      MD_MSUB  = 4'd11,
      MD_MSUBU = 4'd12
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   localparam int unsigned CNT_W = 4;

   function automatic logic is_start_op(input logic [3:0] op);
      logic hit_s;
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: hit_s = 1'b1;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: hit_s = 1'b1;
`endif
         default: hit_s = 1'b0;
      endcase
      return hit_s;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: product, quotient/remainder and (with MDU_MADD_EN)
// accumulate against the current HI/LO, plus a divide-by-zero flag.
module mdu_arith
   import mdu_scheduler_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);
   logic        a_neg_s, b_neg_s;
   logic [31:0] a_mag_s, b_mag_s, divisor_s, quo_mag_s, rem_mag_s, quo_s, rem_s;
   logic [63:0] prod_signed_s, prod_unsigned_s, acc_s, res_s;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   always_comb begin
      a_neg_s         = (op == MD_DIV) & a[31];
      b_neg_s         = (op == MD_DIV) & b[31];
      a_mag_s         = a_neg_s ? (32'd0 - a) : a;
      b_mag_s         = b_neg_s ? (32'd0 - b) : b;
      divisor_s       = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
      quo_mag_s       = a_mag_s / divisor_s;
      rem_mag_s       = a_mag_s % divisor_s;
      quo_s           = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_mag_s) : quo_mag_s;
      rem_s           = a_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;
      prod_signed_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_unsigned_s = {32'd0, a} * {32'd0, b};
      acc_s           = {hi, lo};
      res_s           = 64'd0;
      div0            = 1'b0;
      case (op)
         MD_MULT:  res_s = prod_signed_s;
         MD_MULTU: res_s = prod_unsigned_s;
         MD_DIV, MD_DIVU: begin
            res_s = {rem_s, quo_s};
            div0  = (b == 32'd0);
         end
`ifdef MDU_MADD_EN
         MD_MADD:  res_s = acc_s + prod_signed_s;
         MD_MADDU: res_s = acc_s + prod_unsigned_s;
         MD_MSUB:  res_s = acc_s - prod_signed_s;
         MD_MSUBU: res_s = acc_s - prod_unsigned_s;
`endif
         default:  res_s = 64'd0;
      endcase
   end

`ifndef MDU_MADD_EN
   logic unused_acc_s;
   assign unused_acc_s = ^acc_s;
`endif

   assign res_hi = res_s[63:32];
   assign res_lo = res_s[31:0];

endmodule

// File: rtl/mdu_scheduler.sv
// E-stage multiply/divide sequencer: owns HI/LO, models fixed op latency and
// raises the D-stage stall. Define MDU_MADD_EN to add madd/maddu/msub/msubu.
module mdu_scheduler
   import mdu_scheduler_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDOp,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        D_md_use,
   output logic [31:0] E_MDOut,
   output logic        Busy,
   output logic        Start,
   output logic        Stall_MD,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   mdu_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      hi_r, lo_r, shadow_hi_r, shadow_lo_r;
   logic             div0_r;
   logic [31:0]      arith_hi_s, arith_lo_s;
   logic             arith_div0_s, start_s;

   assign start_s = is_start_op(E_MDOp);

   mdu_arith u_arith (
      .op     (E_MDOp),
      .a      (E_A),
      .b      (E_B),
      .hi     (hi_r),
      .lo     (lo_r),
      .res_hi (arith_hi_s),
      .res_lo (arith_lo_s),
      .div0   (arith_div0_s)
   );

   // Sequencer FSM, latency counter, shadow results and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         hi_r        <= 32'd0;
         lo_r        <= 32'd0;
         shadow_hi_r <= 32'd0;
         shadow_lo_r <= 32'd0;
         div0_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r     <= ST_BUSY;
                  cnt_r       <= is_div_op(E_MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  shadow_hi_r <= arith_hi_s;
                  shadow_lo_r <= arith_lo_s;
                  div0_r      <= arith_div0_s;
               end else if (E_MDOp == MD_MTHI) begin
                  hi_r <= E_A;
               end else if (E_MDOp == MD_MTLO) begin
                  lo_r <= E_A;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               cnt_r <= cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) begin
                  state_r <= ST_IDLE;
                  if (!div0_r) begin
                     hi_r <= shadow_hi_r;
                     lo_r <= shadow_lo_r;
                  end else begin
                     hi_r <= hi_r;
                  end
               end else begin
                  state_r <= ST_BUSY;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Move-from read mux; old HI/LO stays visible while an op is in flight.
   always_comb begin
      case (E_MDOp)
         MD_MFHI: E_MDOut = hi_r;
         MD_MFLO: E_MDOut = lo_r;
         default: E_MDOut = 32'd0;
      endcase
   end

   assign Busy     = (state_r == ST_BUSY);
   assign Start    = start_s;
   assign Stall_MD = D_md_use & (Busy | start_s);
   assign HI       = hi_r;
   assign LO       = lo_r;

endmodule
